// File: rtl/pitch_shift_mc.sv
// ---------------------------------------------------------------------------
// pitch_shift_mc
//
// Multi-channel delay-line pitch shifter. Every channel owns a circular buffer
// of DEPTH samples inside one shared single-port RAM. Two read taps, DEPTH/2
// apart, are crossfaded with a triangular window. The window position and the
// tap distance both come from a per-channel fractional delay accumulator.
// The pitch CV moves that accumulator once per frame. One sequencer visits the
// channels in turn on each sample_clk rising edge.
//
// Optional feature macro: PITCH_SHIFT_INTERP_EN
//   Undefined: integer taps, 4 clk per channel.
//   Defined  : each tap is linearly interpolated between two adjacent samples,
//              6 clk per channel.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   sample_clk in   frame strobe, synchronous to clk; a rising edge starts a frame
//   sample_in  in   CH x W signed audio, channel c at [c*W +: W]
//   pitch      in   CH x W signed pitch CV, same packing
//   sample_out out  CH x W wet output
//   mix_out    out  CH x W (dry>>>1)+(wet>>>1)
//   busy       out  high while clearing RAM or processing a frame
//   overrun    out  sticky; a frame edge arrived while processing
// ---------------------------------------------------------------------------
module pitch_shift_mc #(
  parameter int W     = 16,
  parameter int CH    = 4,
  parameter int DEPTH = 1024,
  parameter int F     = 8,
  parameter int G     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_clk,
  input  logic [CH*W-1:0]   sample_in,
  input  logic [CH*W-1:0]   pitch,
  output logic [CH*W-1:0]   sample_out,
  output logic [CH*W-1:0]   mix_out,
  output logic              busy,
  output logic              overrun
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = (CH > 1) ? $clog2(CH) : 1;
  localparam int DW     = AW + F;
  localparam int RAW    = CW + AW;
  localparam int NWORDS = CH * DEPTH;
  localparam int CLRW   = RAW + 1;

  typedef enum logic [3:0] {
    S_CLEAR,
    S_IDLE,
    S_RD_A,
    S_RD_A1,
    S_RD_B,
    S_RD_B1,
    S_MAC,
    S_WR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CLRW-1:0]        r_clr;
  logic                   r_sclkD;
  logic [CW-1:0]          r_ch;
  logic [AW-1:0]          r_wp;
  logic [DW-1:0]          r_acc [CH];
  logic signed [W-1:0]    r_inLat [CH];
  logic signed [W-1:0]    r_pitchLat [CH];
  logic signed [W-1:0]    r_wetSh [CH];
  logic signed [W-1:0]    r_mixSh [CH];
  logic signed [W-1:0]    r_tapA;
  logic signed [W-1:0]    r_wet;
  logic [CH*W-1:0]        r_sampleOut;
  logic [CH*W-1:0]        r_mixOut;
  logic                   r_overrun;

  logic [W-1:0]           r_mem [0:NWORDS-1];
  logic signed [W-1:0]    r_ramQ;

  logic                   w_sclkEdge;
  logic                   w_clrDone;
  logic                   w_lastCh;
  logic [AW-1:0]          w_di;
  logic [G-1:0]           w_t;
  logic [G:0]             w_gA;
  logic [G:0]             w_gB;
  logic [AW-1:0]          w_addrA0;
  logic [AW-1:0]          w_addrB0;
  logic signed [W-1:0]    w_a;
  logic signed [W-1:0]    w_b;
  logic signed [W+G+1:0]  w_acc;
  logic signed [W-1:0]    w_wet;
  logic signed [W-1:0]    w_mix;
  logic [DW-1:0]          w_inc;
  logic                   w_ramWe;
  logic [RAW-1:0]         w_ramAddr;
  logic [W-1:0]           w_ramWdata;

`ifdef PITCH_SHIFT_INTERP_EN
  logic signed [W-1:0]    r_tapA1;
  logic signed [W-1:0]    r_tapB;
  logic [F-1:0]           w_frac;
  logic [AW-1:0]          w_addrA1;
  logic [AW-1:0]          w_addrB1;

  // s0 + ((s1-s0)*fr >>> F); the result always lies between s0 and s1,
  // so it fits in W bits
  function automatic logic signed [W-1:0] lerp(
    input logic signed [W-1:0] s0,
    input logic signed [W-1:0] s1,
    input logic [F-1:0]        fr
  );
    logic signed [W:0]     diff;
    logic signed [W+F+1:0] prod;
    logic signed [W+F+1:0] step;
    diff = (W+1)'(s1) - (W+1)'(s0);
    prod = diff * $signed({1'b0, fr});
    step = prod >>> F;
    return s0 + W'(step);
  endfunction
`endif

  assign w_sclkEdge = sample_clk & ~r_sclkD;
  assign w_clrDone  = (r_clr == CLRW'(NWORDS));
  assign w_lastCh   = (r_ch == CW'(CH - 1));

  // Integer delay and window position of the channel being processed
  assign w_di     = r_acc[r_ch][DW-1:F];
  assign w_t      = r_acc[r_ch][DW-1 -: G];
  assign w_addrA0 = r_wp - w_di;
  assign w_addrB0 = r_wp - w_di - AW'(DEPTH / 2);

  // Triangular window: gA rises 0..2^G-2 over the first half of the
  // accumulator range and falls back over the second half; gB is the
  // complement, so a constant input passes through unchanged
  always_comb begin
    w_gA = '0;
    if (!w_t[G-1]) begin
      w_gA = {w_t, 1'b0};
    end else begin
      w_gA = {~w_t, 1'b0};
    end
    w_gB = {1'b1, {G{1'b0}}} - w_gA;
  end

`ifdef PITCH_SHIFT_INTERP_EN
  assign w_frac   = r_acc[r_ch][F-1:0];
  assign w_addrA1 = w_addrA0 - AW'(1);
  assign w_addrB1 = w_addrB0 - AW'(1);
  assign w_a      = lerp(r_tapA, r_tapA1, w_frac);
  assign w_b      = lerp(r_tapB, r_ramQ, w_frac);
`else
  assign w_a      = r_tapA;
  assign w_b      = r_ramQ;
`endif

  // Crossfade; the tap B read lands in r_ramQ during MAC
  assign w_acc = (W+G+2)'(w_a) * $signed({1'b0, w_gA})
               + (W+G+2)'(w_b) * $signed({1'b0, w_gB});
  assign w_wet = W'(w_acc >>> G);
  assign w_mix = (r_inLat[r_ch] >>> 1) + (r_wet >>> 1);

  // Pitch CV scaled so that full scale moves the delay by one sample per frame
  assign w_inc = DW'(r_pitchLat[r_ch] >>> (W - 1 - F));

  // Next-state logic. The CLEAR state holds one extra cycle after the last
  // word is written before handing over to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (w_clrDone) w_next = S_IDLE;
      S_IDLE:  if (w_sclkEdge) w_next = S_RD_A;
`ifdef PITCH_SHIFT_INTERP_EN
      S_RD_A:  w_next = S_RD_A1;
      S_RD_A1: w_next = S_RD_B;
      S_RD_B:  w_next = S_RD_B1;
      S_RD_B1: w_next = S_MAC;
`else
      S_RD_A:  w_next = S_RD_B;
      S_RD_B:  w_next = S_MAC;
`endif
      S_MAC:   w_next = S_WR;
      S_WR:    w_next = w_lastCh ? S_DONE : S_RD_A;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  // State register; reset always restarts the RAM clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  // Single RAM port: reads are issued in the RD states, the only writes are
  // the clear sweep and the per-channel input write, which follows its reads
  always_comb begin
    w_ramWe    = 1'b0;
    w_ramAddr  = '0;
    w_ramWdata = '0;
    case (r_state)
      S_CLEAR: begin
        w_ramWe   = !w_clrDone;
        w_ramAddr = r_clr[RAW-1:0];
      end
      S_RD_A:  w_ramAddr = {r_ch, w_addrA0};
      S_RD_B:  w_ramAddr = {r_ch, w_addrB0};
`ifdef PITCH_SHIFT_INTERP_EN
      S_RD_A1: w_ramAddr = {r_ch, w_addrA1};
      S_RD_B1: w_ramAddr = {r_ch, w_addrB1};
`endif
      S_WR: begin
        w_ramWe    = 1'b1;
        w_ramAddr  = {r_ch, r_wp};
        w_ramWdata = r_inLat[r_ch];
      end
      default: ;
    endcase
  end

  // Synchronous-read RAM, one access per cycle
  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_mem[w_ramAddr] <= w_ramWdata;
    end else begin
      r_ramQ <= r_mem[w_ramAddr];
    end
  end

  // Datapath: frame latching, tap capture, accumulator update, shadow and
  // output registers. Reset clears shadows so an aborted frame leaves nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr       <= '0;
      r_sclkD     <= 1'b0;
      r_ch        <= '0;
      r_wp        <= '0;
      r_tapA      <= '0;
      r_wet       <= '0;
      r_sampleOut <= '0;
      r_mixOut    <= '0;
      r_overrun   <= 1'b0;
`ifdef PITCH_SHIFT_INTERP_EN
      r_tapA1     <= '0;
      r_tapB      <= '0;
`endif
      for (int i = 0; i < CH; i++) begin
        r_acc[i]      <= '0;
        r_inLat[i]    <= '0;
        r_pitchLat[i] <= '0;
        r_wetSh[i]    <= '0;
        r_mixSh[i]    <= '0;
      end
    end else begin
      r_sclkD <= sample_clk;

      if (w_sclkEdge && (r_state != S_CLEAR) && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_CLEAR: begin
          if (!w_clrDone) r_clr <= r_clr + CLRW'(1);
        end
        S_IDLE: begin
          if (w_sclkEdge) begin
            r_ch <= '0;
            for (int i = 0; i < CH; i++) begin
              r_inLat[i]    <= sample_in[i*W +: W];
              r_pitchLat[i] <= pitch[i*W +: W];
            end
          end
        end
`ifdef PITCH_SHIFT_INTERP_EN
        S_RD_A1: r_tapA  <= r_ramQ;
        S_RD_B:  r_tapA1 <= r_ramQ;
        S_RD_B1: r_tapB  <= r_ramQ;
`else
        S_RD_B:  r_tapA  <= r_ramQ;
`endif
        S_MAC:   r_wet   <= w_wet;
        S_WR: begin
          r_acc[r_ch]   <= r_acc[r_ch] + w_inc;
          r_wetSh[r_ch] <= r_wet;
          r_mixSh[r_ch] <= w_mix;
          if (!w_lastCh) r_ch <= r_ch + CW'(1);
        end
        S_DONE: begin
          for (int i = 0; i < CH; i++) begin
            r_sampleOut[i*W +: W] <= r_wetSh[i];
            r_mixOut[i*W +: W]    <= r_mixSh[i];
          end
          r_wp <= r_wp + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sample_out = r_sampleOut;
  assign mix_out    = r_mixOut;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pitch_shift_mc.sv
// ---------------------------------------------------------------------------
// tb_pitch_shift_mc
//
// Self-checking bench for pitch_shift_mc with a reduced buffer (DEPTH=64).
// The reference model keeps the full input history of every channel and
// reads the two taps as "the sample written k frames ago", with the delay
// accumulator kept as a plain integer.
// ---------------------------------------------------------------------------
module tb_pitch_shift_mc;

  localparam int W     = 16;
  localparam int CH    = 4;
  localparam int DEPTH = 64;
  localparam int F     = 8;
  localparam int G     = 8;
  localparam int AW    = 6;
  localparam int DW    = AW + F;
  localparam int MAXF  = 2048;
  localparam int NCLR  = CH * DEPTH + 1;
`ifdef PITCH_SHIFT_INTERP_EN
  localparam int PERCH = 6;
`else
  localparam int PERCH = 4;
`endif
  localparam int LAT    = PERCH * CH + 2;
  localparam int BUDGET = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_clk;
  logic [CH*W-1:0] sample_in;
  logic [CH*W-1:0] pitch;
  logic [CH*W-1:0] sample_out;
  logic [CH*W-1:0] mix_out;
  logic            busy;
  logic            overrun;

  int checkCount = 0;
  int errorCount = 0;

  int hist [CH][MAXF];
  int accD [CH];
  int stimIn [CH];
  int stimPitch [CH];
  int expWet [CH];
  int expMix [CH];
  int frameIdx;
  bit expOverrun;

  always #5 clk = ~clk;

  pitch_shift_mc #(.W(W), .CH(CH), .DEPTH(DEPTH), .F(F), .G(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .sample_in  (sample_in),
    .pitch      (pitch),
    .sample_out (sample_out),
    .mix_out    (mix_out),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic checkValue(input string tag, input int idx,
                            input logic [W-1:0] observed,
                            input logic [W-1:0] expected);
    checkCount++;
    assert (observed === expected)
      else begin
        errorCount++;
        $error("[TB] FAIL %s[%0d] observed=%h expected=%h", tag, idx, observed, expected);
      end
  endtask

  function automatic int rand16();
    logic signed [W-1:0] v;
    v = W'($urandom);
    return int'(v);
  endfunction

  // Sample written 'delay' frames back, where delay 0 means a full buffer
  // back because the reads happen before the current write
  function automatic int tapAt(int c, int delay);
    int age;
    int idx;
    age = delay % DEPTH;
    if (age == 0) age = DEPTH;
    idx = frameIdx - age;
    return (idx >= 0) ? hist[c][idx] : 0;
  endfunction

  function automatic int modelTap(int c, int delay, int fr);
`ifdef PITCH_SHIFT_INTERP_EN
    int s0;
    int s1;
    s0 = tapAt(c, delay);
    s1 = tapAt(c, delay + 1);
    return s0 + (((s1 - s0) * fr) >>> F);
`else
    return tapAt(c, delay) + 0 * fr;
`endif
  endfunction

  function automatic void modelFrame();
    int di;
    int t;
    int fr;
    int gA;
    int a;
    int b;
    longint sum;
    for (int c = 0; c < CH; c++) begin
      di = accD[c] >> F;
      t  = accD[c] >> (DW - G);
      fr = accD[c] % (1 << F);
      gA = (t < (1 << (G - 1))) ? 2 * t : 2 * ((1 << G) - 1 - t);
      a  = modelTap(c, di, fr);
      b  = modelTap(c, di + DEPTH / 2, fr);
      sum = longint'(a) * gA + longint'(b) * ((1 << G) - gA);
      expWet[c] = int'(sum >>> G);
      expMix[c] = (stimIn[c] >>> 1) + (expWet[c] >>> 1);
      hist[c][frameIdx] = stimIn[c];
      accD[c] = (accD[c] + (stimPitch[c] >>> (W - 1 - F))) & ((1 << DW) - 1);
    end
    frameIdx++;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < CH; c++) begin
      accD[c]   = 0;
      expWet[c] = 0;
      expMix[c] = 0;
    end
    frameIdx   = 0;
    expOverrun = 1'b0;
  endfunction

  task automatic checkOutput();
    for (int c = 0; c < CH; c++) begin
      checkValue("sample_out", c, sample_out[c*W +: W], W'(expWet[c]));
      checkValue("mix_out", c, mix_out[c*W +: W], W'(expMix[c]));
    end
    checkValue("overrun", 0, W'(overrun), W'(expOverrun));
    checkValue("busy_idle", 0, W'(busy), W'(0));
  endtask

  // One frame: drive stimIn/stimPitch, pulse sample_clk (optionally a second
  // pulse 3 clk later), wait for busy to drop, then compare with the model
  task automatic applyStimulus(input bit doubleEdge);
    int cycles;
    for (int c = 0; c < CH; c++) begin
      sample_in[c*W +: W] = W'(stimIn[c]);
      pitch[c*W +: W]     = W'(stimPitch[c]);
    end
    @(negedge clk);
    sample_clk = 1'b1;
    cycles = 0;
    while (cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) sample_clk = 1'b0;
      if (doubleEdge && cycles == 3) sample_clk = 1'b1;
      if (doubleEdge && cycles == 4) sample_clk = 1'b0;
      if (!busy && cycles > 4) break;
    end
    sample_clk = 1'b0;
    checkValue("latency", frameIdx, W'(cycles), W'(LAT));
    modelFrame();
    if (doubleEdge) expOverrun = 1'b1;
    checkOutput();
  endtask

  // Release reset and count negedge samples with busy high, pulsing
  // sample_clk throughout the clear
  task automatic waitClear(output int cnt);
    cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    while (busy && cnt < 2 * NCLR) begin
      cnt++;
      sample_clk = ((cnt % 8) < 2);
      @(negedge clk);
    end
    sample_clk = 1'b0;
  endtask

  task automatic runImpulse();
    for (int f = 0; f < DEPTH / 2 + 4; f++) begin
      for (int c = 0; c < CH; c++) begin
        stimIn[c]    = (f == 0 && c == 0) ? 16'h4000 : 0;
        stimPitch[c] = 0;
      end
      applyStimulus(1'b0);
      if (f == 0) checkValue("impulse_mix0", f, mix_out[0 +: W], 16'h2000);
      checkValue("impulse_wet0", f, sample_out[0 +: W],
                 (f == DEPTH / 2) ? 16'h4000 : 16'h0000);
    end
  endtask

  initial begin
    int cnt;
    int wet0;
    rst        = 1'b0;
    sample_clk = 1'b0;
    sample_in  = '0;
    pitch      = '0;
    modelReset();

    // Reset state
    repeat (3) @(negedge clk);
    checkValue("rst_busy", 0, W'(busy), W'(1));
    checkValue("rst_overrun", 0, W'(overrun), W'(0));
    for (int c = 0; c < CH; c++) begin
      checkValue("rst_sample_out", c, sample_out[c*W +: W], W'(0));
      checkValue("rst_mix_out", c, mix_out[c*W +: W], W'(0));
    end

    // Clear length, sample_clk ignored during clear
    waitClear(cnt);
    checkValue("clear_len", 0, W'(cnt), W'(NCLR));
    repeat (4) @(negedge clk);
    checkOutput();

    // Impulse with zero pitch
    $display("[TB] impulse response");
    runImpulse();

    // Sine on ch0/ch1 (ch1 pitched up 1.5x), random on ch2/ch3
    $display("[TB] pitched sine and random channels");
    for (int f = 0; f < 80; f++) begin
      stimIn[0]    = int'(12000.0 * $sin(6.283185307 * f / 16.0));
      stimIn[1]    = stimIn[0];
      stimIn[2]    = rand16();
      stimIn[3]    = rand16();
      stimPitch[0] = 0;
      stimPitch[1] = -16'sh4000;
      stimPitch[2] = rand16();
      stimPitch[3] = rand16();
      applyStimulus(1'b0);
    end

    // Constant input across the accumulator wrap
    $display("[TB] constant input across accumulator wrap");
    for (int f = 0; f < DEPTH + 300; f++) begin
      for (int c = 0; c < CH; c++) begin
        stimIn[c]    = 16'h1000;
        stimPitch[c] = 16'h2000;
      end
      applyStimulus(1'b0);
      if (f > DEPTH + 1 && (f % 40) == 0) begin
        wet0 = int'($signed(sample_out[0 +: W]));
        checkValue("const_window", f, W'((wet0 >= 16'h0fff) && (wet0 <= 16'h1001)), W'(1));
      end
    end

    // Second edge while busy is dropped and sets sticky overrun
    $display("[TB] overrun");
    for (int c = 0; c < CH; c++) begin
      stimIn[c]    = rand16();
      stimPitch[c] = rand16();
    end
    applyStimulus(1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < CH; c++) begin
        stimIn[c]    = rand16();
        stimPitch[c] = rand16();
      end
      applyStimulus(1'b0);
    end

    // Reset during channel 2 MAC
    $display("[TB] reset mid-frame");
    for (int c = 0; c < CH; c++) begin
      sample_in[c*W +: W] = W'(rand16());
      pitch[c*W +: W]     = W'(rand16());
    end
    @(negedge clk);
    sample_clk = 1'b1;
    @(negedge clk);
    sample_clk = 1'b0;
    repeat (3 * PERCH - 2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("midrst_busy", 0, W'(busy), W'(1));
    checkValue("midrst_overrun", 0, W'(overrun), W'(0));
    for (int c = 0; c < CH; c++) begin
      checkValue("midrst_sample_out", c, sample_out[c*W +: W], W'(0));
      checkValue("midrst_mix_out", c, mix_out[c*W +: W], W'(0));
    end
    modelReset();
    waitClear(cnt);
    checkValue("clear_len2", 0, W'(cnt), W'(NCLR));
    runImpulse();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pitch_shift_mc.md
Name: pitch_shift_mc

Overview:
- Multi-channel delay-line pitch shifter for the eurorack-pmod core set; the parametrised successor to the single-channel transpose path.
- Each of CH channels writes into its own circular buffer. Two read taps, DEPTH/2 apart, are crossfaded with a triangular window.
- A per-channel fractional delay accumulator, driven by a per-channel pitch CV, moves the taps.
- All channels are processed serially by one sequencer sharing one RAM, once per sample_clk rising edge. Dry and wet outputs are provided per channel.

Parameters:
- W, 16, sample and CV width (signed).
- CH, 4, channel count (1..8).
- DEPTH, 1024, buffer length per channel in samples; power of two; AW = log2(DEPTH).
- F, 8, fractional bits of the delay accumulator; F <= W-1.
- G, 8, crossfade gain resolution in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sample_clk  in  1  sample strobe, synchronous to clk; rising edge starts a frame
- sample_in  in  CH*W  signed audio; channel c at [c*W +: W]
- pitch  in  CH*W  signed pitch CV per channel, same packing
- sample_out  out  CH*W  wet (shifted) output per channel
- mix_out  out  CH*W  (dry>>>1)+(wet>>>1) per channel
- busy  out  1  high while clearing or processing a frame
- overrun  out  1  sticky; set when a frame start arrives while busy after clear

Behaviour:
- Reset (rst low, asynchronous):
  - sample_out, mix_out and overrun go to 0; busy goes to 1.
  - Write pointer wp = 0; all accumulators D[c] = 0; FSM enters CLEAR.
  - Reset asserted mid-frame aborts the frame and discards the partial shadow results.
- CLEAR: writes 0 to all CH*DEPTH RAM words, one per clk, then enters IDLE with busy = 0. sample_clk edges during CLEAR are ignored and do not set overrun.
- IDLE: a sample_clk rising edge (registered edge detect) latches sample_in and pitch, sets c = 0, sets busy = 1 and enters RD_A.
- Per channel c, with Di = D[c][AW+F-1:F]:
  - RD_A: issue a read of {c, wp-Di}.
  - RD_B: capture a; issue a read of {c, wp-Di-DEPTH/2}.
  - MAC: capture b. Let t = D[c] top G bits. Then gA = (t < 2^(G-1)) ? 2t : 2(2^G-1-t), and gB = 2^G - gA. Compute wet = (a*gA + b*gB) >>> G; because gA+gB = 2^G the result never overflows W bits.
  - WR:
    - Write the latched input to {c, wp}.
    - Update D[c] <= D[c] + sext(pitch[c] >>> (W-1-F)), wrapping modulo DEPTH*2^F.
    - Store wet and the mix value into shadow registers.
    - If c = CH-1, go to DONE; otherwise increment c and go to RD_A.
- DONE: copy all shadow registers to sample_out and mix_out in the same cycle (all channels update together), set wp <= wp+1 (wraps at DEPTH), set busy = 0 and return to IDLE.
- Reads always precede the write within a channel. Delay 0 therefore returns the DEPTH-old sample.
- Latency: outputs update 4*CH+2 clk after the sample_clk edge (6*CH+2 with the interpolation feature). The integrator guarantees this is shorter than the sample period.
- Pitch mapping: the delay change per sample is pitch/2^(W-1) samples.
  - 0 gives unity pitch.
  - -0.5 FS gives ratio 1.5.
  - +0.5 FS gives ratio 0.5.
- A sample_clk edge while busy (outside CLEAR) is dropped and sets overrun.
- Mix arithmetic uses arithmetic shifts with no saturation, which is safe by construction.
- RAM: one synchronous-read block of CH*DEPTH x W, one read or write port per cycle, 1-cycle read latency.

Optional Feature:
- Macro: PITCH_SHIFT_INTERP_EN.
- Defined:
  - Each tap reads samples at Di and Di+1 (adjacent, older). The 4 reads per channel take 2 extra cycles (RD_A1, RD_B1).
  - Each tap is linearly interpolated: x = s0 + (((s1-s0) * fr) >>> F), where fr = D[c][F-1:0], with a W+1-bit difference and no overflow.
- Undefined: integer-tap (truncation) behaviour as above, 4 cycles per channel.

Test Plan:
- Reset then idle: busy high for exactly CH*DEPTH+1 clk after rst release. All outputs stay 0; sample_clk pulses during CLEAR leave overrun = 0.
- pitch = 0 on all channels, impulse 0x4000 on channel 0 at frame n: sample_out0 = 0x4000 at frame n+DEPTH/2 and 0 at every other frame; mix_out0 = 0x2000 at frame n; the other channels stay 0.
- Channel 1 pitch = -0x4000 (ratio 1.5), channel 0 pitch = 0, both fed a sine: D[1] decreases by 0x80 (F=8) per frame, channel 0 is an exact delayed copy, and no channel crosstalk is observed.
- Constant input 0x1000 with pitch = 0x2000 after one full buffer fill: sample_out stays 0x1000 ±1 LSB across the accumulator wrap (verifies gA+gB = 2^G).
- Two sample_clk edges 3 clk apart with CH = 4: the second edge is dropped, overrun = 1 and stays high until rst, and the outputs of the first frame are correct.
- rst asserted during MAC of channel 2: outputs are 0 immediately, busy = 1 and CLEAR restarts. The first post-clear frame gives impulse response identical to the clean-start case.
